buffer_sequencer: RTL and testbench

BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

---
 rtl/buffer_sequencer_pkg.sv | 25 ++
 rtl/buffer_sequencer_frame_counter.sv | 30 +++
 rtl/buffer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_buffer_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_sequencer_pkg.sv
// Shared definitions for the buffer sequencer: FSM state encoding and
// default geometry of the external row buffer.
package buffer_sequencer_pkg;

    // Default row width, buffer depth in rows, and log2 of that depth
    localparam int DEF_ROW       = 19;
    localparam int DEF_WIDTH     = 128;
    localparam int DEF_LOG_WIDTH = 7;

    // Sequencer phases. IDLE always separates two phases, so the buffer's
    // auto-incrementing address counters rewind to 0 between phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } seq_state_t;

    // Effective frame length: 0 or anything past the buffer depth means "full depth"
    function automatic logic [DEF_LOG_WIDTH:0] clamp_len(input logic [DEF_LOG_WIDTH:0] req,
                                                         input logic [DEF_LOG_WIDTH:0] depth);
        return ((req == '0) || (req > depth)) ? depth : req;
    endfunction

endpackage

// File: rtl/buffer_sequencer_frame_counter.sv
// Row down-counter shared by the FILL and DRAIN phases. Loaded with the
// frame length when a phase starts; 'last' flags the final row of the phase.
module frame_counter #(
    parameter int LOG_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LOG_WIDTH:0]   load_val,
    input  logic                 dec,
    output logic [LOG_WIDTH:0]   cnt,
    output logic                 last
);

    localparam logic [LOG_WIDTH:0] ONE = (LOG_WIDTH+1)'(1);

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign last = (cnt == ONE);

endmodule

// File: rtl/buffer_sequencer.sv
// Capture/playback sequencer for an external auto-addressed row buffer.
// A frame of L rows is written in FILL (one row per cycle, no backpressure),
// then played back in DRAIN; the buffer returns read data one cycle after
// mem_we, so playback output trails DRAIN by one cycle and a single FLUSH
// cycle delivers the final row.
// Build option: define SEQ_REPLAY_EN to keep a drained frame for replay.
module buffer_sequencer
    import buffer_sequencer_pkg::*;
#(
    parameter int ROW       = DEF_ROW,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG_WIDTH = DEF_LOG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LOG_WIDTH:0]   len,
    input  logic                 wr_start,
    input  logic [ROW-1:0]       wr_data,
    output logic                 wr_take,
    input  logic                 rd_start,
    output logic                 rd_valid,
    output logic [ROW-1:0]       rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 full,
    output logic                 err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ROW-1:0]       mem_din,
    input  logic [ROW-1:0]       mem_dout
);

    localparam logic [LOG_WIDTH:0] DEPTH = (LOG_WIDTH+1)'(WIDTH);

    seq_state_t           state, next_state;
    logic [LOG_WIDTH:0]   len_q;      // L of the stored / in-flight frame
    logic [LOG_WIDTH:0]   eff_len;
    logic                 stored;     // buffer holds a complete frame
    logic                 full_q;     // stored frame not yet drained
    logic                 err_q;
    logic                 vld_q;      // read data from the previous DRAIN cycle is on mem_dout
    logic                 last_q;

    logic                 cnt_load;
    logic [LOG_WIDTH:0]   cnt_val;
    logic                 cnt_dec;
    logic [LOG_WIDTH:0]   cnt;
    logic                 cnt_last;
    logic                 start_wr;
    logic                 fill_done;
    logic                 flush_done;
    logic                 err_set;

    always_comb begin
        eff_len = ((len == '0) || (len > DEPTH)) ? DEPTH : len;
    end

    frame_counter #(
        .LOG_WIDTH (LOG_WIDTH)
    ) u_frame_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    // Next-state and phase control; requests while busy are dropped and flagged
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = eff_len;
        cnt_dec    = 1'b0;
        start_wr   = 1'b0;
        fill_done  = 1'b0;
        flush_done = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start && full_q) begin
                    // a pending frame wins over a simultaneous capture
                    next_state = DRAIN;
                    cnt_load   = 1'b1;
                    cnt_val    = len_q;
                end else if (wr_start) begin
                    // new capture, possibly overwriting a stored frame
                    next_state = FILL;
                    cnt_load   = 1'b1;
                    start_wr   = 1'b1;
                end else if (rd_start && stored) begin
                    // replay of an already drained frame
                    next_state = DRAIN;
                    cnt_load   = 1'b1;
                    cnt_val    = len_q;
                end else if (rd_start) begin
                    err_set    = 1'b1;
                end
            end
            FILL: begin
                cnt_dec = 1'b1;
                err_set = wr_start | rd_start;
                if (cnt_last) begin
                    next_state = IDLE;
                    fill_done  = 1'b1;
                end
            end
            DRAIN: begin
                cnt_dec = 1'b1;
                err_set = wr_start | rd_start;
                if (cnt_last) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                err_set    = wr_start | rd_start;
                next_state = IDLE;
                flush_done = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, frame bookkeeping and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            len_q  <= '0;
            stored <= 1'b0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (start_wr) begin
                // the old frame is gone as soon as overwriting begins
                len_q  <= eff_len;
                stored <= 1'b0;
                full_q <= 1'b0;
            end
            if (fill_done) begin
                stored <= 1'b1;
                full_q <= 1'b1;
            end
            if (flush_done) begin
                full_q <= 1'b0;
`ifdef SEQ_REPLAY_EN
                stored <= 1'b1;
`else
                stored <= 1'b0;
`endif
            end
        end
    end

    // Read data lags mem_we by one cycle, so qualify it one cycle behind DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= (state == DRAIN);
            last_q <= (state == DRAIN) && cnt_last;
        end
    end

    assign wr_take  = (state == FILL);
    assign mem_en   = (state == FILL);
    assign mem_we   = (state == DRAIN);
    assign mem_din  = (state == FILL) ? wr_data : '0;
    assign rd_valid = vld_q;
    assign rd_last  = last_q;
    assign rd_data  = vld_q ? mem_dout : '0;
    assign busy     = (state != IDLE);
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer with a behavioural auto-addressed row
// buffer and a scoreboard of expected playback rows.
module tb_buffer_sequencer;

    localparam int ROW   = 19;
    localparam int WIDTH = 128;
    localparam int LW    = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [LW:0]     len;
    logic            wr_start;
    logic [ROW-1:0]  wr_data;
    logic            wr_take;
    logic            rd_start;
    logic            rd_valid;
    logic [ROW-1:0]  rd_data;
    logic            rd_last;
    logic            busy;
    logic            full;
    logic            err;
    logic            mem_en;
    logic            mem_we;
    logic [ROW-1:0]  mem_din;
    logic [ROW-1:0]  mem_dout;

    always #5 clk = ~clk;

    buffer_sequencer #(.ROW(ROW), .WIDTH(WIDTH), .LOG_WIDTH(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .len      (len),
        .wr_start (wr_start),
        .wr_data  (wr_data),
        .wr_take  (wr_take),
        .rd_start (rd_start),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .full     (full),
        .err      (err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Row buffer model: separate write/read address counters that rewind
    // whenever a cycle has neither enable; read data is registered.
    logic [ROW-1:0] mem [0:255];
    logic [7:0]     wp = '0;
    logic [7:0]     rp = '0;
    initial mem_dout = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            mem[wp] <= mem_din;
            wp      <= wp + 8'd1;
        end
        if (mem_we) begin
            mem_dout <= mem[rp];
            rp       <= rp + 8'd1;
        end
        if (!mem_en && !mem_we) begin
            wp <= '0;
            rp <= '0;
        end
    end

    typedef struct {
        logic [ROW-1:0] data;
        logic           last;
    } exp_t;

    exp_t           exp_q[$];
    logic [ROW-1:0] frame[$];
    int             n_chk  = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; outputs are examined on the falling edge
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        chk("en_we_exclusive", {31'd0, mem_en & mem_we}, 32'd0);
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_last", {31'd0, rd_last}, {31'd0, e.last});
            end
        end else begin
            chk("rd_last_unqualified", {31'd0, rd_last}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_start = 1'b0; rd_start = 1'b0; len = '0; wr_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
        frame.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_full"},     {31'd0, full},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
        chk({tag, "_mem_en"},   {31'd0, mem_en},   32'd0);
        chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        chk({tag, "_wr_take"},  {31'd0, wr_take},  32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_mem_din"},  32'(mem_din),      32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),      32'd0);
    endtask

    // Capture n rows base, base+1, ... after a wr_start with the given len
    task automatic fill(input logic [LW:0] l, input logic [ROW-1:0] base, input int n);
        len = l; wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        frame.delete();
        for (int i = 0; i < n; i++) begin
            wr_data = ROW'(base + ROW'(i));
            #1;
            chk("wr_take", {31'd0, wr_take}, 32'd1);
            chk("mem_din", 32'(mem_din), 32'(wr_data));
            frame.push_back(wr_data);
            cyc();
        end
        wr_data = '0;
        chk("fill_end_busy", {31'd0, busy}, 32'd0);
        chk("fill_end_full", {31'd0, full}, 32'd1);
        chk("fill_end_mem_en", {31'd0, mem_en}, 32'd0);
    endtask

    // Play back the current frame; optionally raise wr_start alongside
    // rd_start (both) or during the first DRAIN cycle (mid_wr)
    task automatic drain(input bit both, input bit mid_wr);
        int k;
        int l;
        l = frame.size();
        for (int i = 0; i < l; i++) begin
            exp_q.push_back('{data: frame[i], last: (i == l - 1)});
        end
        rd_start = 1'b1; wr_start = both;
        cyc();
        rd_start = 1'b0; wr_start = 1'b0;
        for (k = 1; k <= l + 8; k++) begin
            wr_start = mid_wr && (k == 1);
            cyc();
            wr_start = 1'b0;
            if (!busy && exp_q.size() == 0) break;
        end
        chk("drain_cycles", 32'(k), 32'(l + 1));
        chk("drain_rows_left", 32'(exp_q.size()), 32'd0);
        chk("drain_full_clear", {31'd0, full}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; wr_start = 1'b0; rd_start = 1'b0; len = '0; wr_data = '0;
        do_reset();
        chk_all_zero("reset");
        chk("reset_rd_last", {31'd0, rd_last}, 32'd0);

        // read with nothing stored
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        chk("nofr_err", {31'd0, err}, 32'd1);
        chk("nofr_busy", {31'd0, busy}, 32'd0);
        chk("nofr_mem_we", {31'd0, mem_we}, 32'd0);
        cyc();
        chk("nofr_mem_we2", {31'd0, mem_we}, 32'd0);
        chk("nofr_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // basic capture and playback, then replay behaviour
        fill(8'd4, 19'h1, 4);
        drain(1'b0, 1'b0);
        chk("basic_err", {31'd0, err}, 32'd0);
`ifdef SEQ_REPLAY_EN
        drain(1'b0, 1'b0);
        chk("replay_err", {31'd0, err}, 32'd0);
`else
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        chk("replay_err", {31'd0, err}, 32'd1);
        chk("replay_busy", {31'd0, busy}, 32'd0);
        chk("replay_mem_we", {31'd0, mem_we}, 32'd0);
`endif
        do_reset();

        // default and oversize length both give the full buffer depth
        fill(8'd0, 19'h0, WIDTH);
        drain(1'b0, 1'b0);
        fill(8'd200, 19'h100, WIDTH);
        drain(1'b0, 1'b0);
        chk("depth_err", {31'd0, err}, 32'd0);

        // write request during drain is flagged and does not disturb it
        do_reset();
        fill(8'd5, 19'h20, 5);
        drain(1'b0, 1'b1);
        chk("wr_in_drain_err", {31'd0, err}, 32'd1);

        // reset after two of four FILL cycles
        do_reset();
        len = 8'd4; wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        wr_data = 19'h7;
        cyc();
        wr_data = 19'h8;
        cyc();
        rst = 1'b1;
        cyc();
        chk_all_zero("midfill_rst");
        rst = 1'b0;
        fill(8'd2, 19'hA, 2);
        drain(1'b0, 1'b0);

        // overwrite of a full frame, no error
        fill(8'd4, 19'h30, 4);
        fill(8'd2, 19'h40, 2);
        drain(1'b0, 1'b0);
        chk("overwrite_err", {31'd0, err}, 32'd0);

        // simultaneous requests with a pending frame: playback wins
        fill(8'd3, 19'h50, 3);
        drain(1'b1, 1'b0);
        chk("both_full_err", {31'd0, err}, 32'd0);

        // simultaneous requests with nothing pending: capture wins
        do_reset();
        len = 8'd2; wr_start = 1'b1; rd_start = 1'b1;
        cyc();
        wr_start = 1'b0; rd_start = 1'b0;
        chk("both_empty_fill", {31'd0, wr_take}, 32'd1);
        chk("both_empty_mem_we", {31'd0, mem_we}, 32'd0);
        cyc();
        cyc();
        chk("both_empty_full", {31'd0, full}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
